// File: rtl/quiz_round_controller_pkg.sv
// Shared types for the quiz round controller: FSM states, operator codes and
// the arithmetic used both to compute the shown result and to judge guesses.
package quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_CALC  = 3'd2,
    ST_ARM   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_JUDGE = 3'd5,
    ST_SHOW  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Division by zero yields 0 here; callers that judge must reject it separately.
  function automatic logic [6:0] apply_op(input logic [3:0] a, input logic [3:0] b, input op_e op);
    logic [6:0] r;
    case (op)
      OP_ADD:  r = 7'(a) + 7'(b);
      OP_SUB:  r = 7'(a) - 7'(b);
      OP_MUL:  r = 7'(a) * 7'(b);
      default: r = (b == 4'd0) ? 7'd0 : 7'(a / b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quiz_round_controller_if.sv
// Player-side inputs and display/motor-side outputs of one quiz round controller.
interface quiz_round_if;
  logic       set_i;
  logic [3:0] switch_i;
  logic [3:0] num1_o;
  logic [3:0] num2_o;
  logic [1:0] operator_o;
  logic [6:0] result_o;
  logic [6:0] score_o;
  logic       round_active_o;
  logic       correct_pulse_o;
  logic       timeout_pulse_o;
  logic       motor_en_o;
  logic [2:0] state_dbg_o;

  modport slave (
    input  set_i, switch_i,
    output num1_o, num2_o, operator_o, result_o, score_o,
           round_active_o, correct_pulse_o, timeout_pulse_o, motor_en_o, state_dbg_o
  );

  modport master (
    output set_i, switch_i,
    input  num1_o, num2_o, operator_o, result_o, score_o,
           round_active_o, correct_pulse_o, timeout_pulse_o, motor_en_o, state_dbg_o
  );
endinterface

// File: rtl/quiz_round_controller_lfsr.sv
// 16-bit right-shifting Galois LFSR, free running; a nonzero seed keeps it out of
// the all-zero lockup state.
module quiz_lfsr16
  import quiz_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= SEED;
    else        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/quiz_round_controller.sv
// One round of the operator-guessing quiz: draw operands, show the result, wait
// for a fresh switch guess or a timeout, judge it and hold the outcome on display.
module quiz_round_controller
  import quiz_pkg::*;
#(
  parameter int unsigned ANSWER_TIMEOUT = 250000000,
  parameter int unsigned SHOW_CYCLES    = 50000000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned MAX_SCORE      = 99
) (
  input logic         clk,
  input logic         reset,
  quiz_round_if.slave bus
);

  localparam logic [31:0] TMO_LAST  = 32'(ANSWER_TIMEOUT - 1);
  localparam logic [31:0] SHOW_LAST = 32'(SHOW_CYCLES - 1);
  localparam logic [6:0]  SCORE_MAX = 7'(MAX_SCORE);

  state_e      state_q, state_d;
  op_e         op_q, op_d, gen_op, guess_op;
  logic [15:0] lfsr;
  logic        set_q;
  logic [3:0]  num1_q, num1_d, num2_q, num2_d, guess_q, guess_d;
  logic [3:0]  gen_a, gen_b;
  logic [6:0]  result_q, result_d, score_q, score_d;
  logic [31:0] timer_q, timer_d;
  logic        correct_q, correct_d, cpulse_q, cpulse_d, tpulse_q, tpulse_d;
  logic        guess_ok, timed_out;
  logic        unused_lfsr_hi;

  quiz_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .state_o(lfsr));

  assign unused_lfsr_hi = ^lfsr[15:10];

  assign gen_a  = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];
  assign gen_b  = (lfsr[7:4] >= 4'd10) ? lfsr[7:4] - 4'd10 : lfsr[7:4];
  // A divide by a zero right operand would have no answer, so it falls back to add.
  assign gen_op = (op_e'(lfsr[9:8]) == OP_DIV && ((gen_a < gen_b) ? gen_a : gen_b) == 4'd0)
                  ? OP_ADD : op_e'(lfsr[9:8]);

  always_comb begin
    guess_op = OP_ADD;
    if (guess_q[1]) guess_op = OP_SUB;
    if (guess_q[2]) guess_op = OP_MUL;
    if (guess_q[3]) guess_op = OP_DIV;
  end

  assign guess_ok  = $onehot(guess_q) && !(guess_op == OP_DIV && num2_q == 4'd0)
                     && (apply_op(num1_q, num2_q, guess_op) == result_q);
  assign timed_out = (timer_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    op_d      = op_q;
    result_d  = result_q;
    score_d   = score_q;
    guess_d   = guess_q;
    correct_d = correct_q;
    timer_d   = timer_q + 32'd1;
    cpulse_d  = 1'b0;
    tpulse_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.set_i && !set_q) state_d = ST_GEN;
      ST_GEN: begin
        num1_d  = (gen_a >= gen_b) ? gen_a : gen_b;
        num2_d  = (gen_a >= gen_b) ? gen_b : gen_a;
        op_d    = gen_op;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        result_d = apply_op(num1_q, num2_q, op_q);
        timer_d  = 32'd0;
        state_d  = ST_ARM;
      end
      ST_ARM: begin
        if (timed_out) begin
          tpulse_d = 1'b1;
          timer_d  = 32'd0;
          state_d  = ST_SHOW;
        end else if (bus.switch_i == 4'd0) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An answer arriving on the timeout cycle still counts.
        if (bus.switch_i != 4'd0) begin
          guess_d = bus.switch_i;
          state_d = ST_JUDGE;
        end else if (timed_out) begin
          tpulse_d = 1'b1;
          timer_d  = 32'd0;
          state_d  = ST_SHOW;
        end
      end
      ST_JUDGE: begin
        if (guess_ok) begin
          cpulse_d  = 1'b1;
          correct_d = 1'b1;
          if (score_q < SCORE_MAX) score_d = score_q + 7'd1;
        end
        timer_d = 32'd0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          correct_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      set_q     <= 1'b0;
      num1_q    <= 4'd0;
      num2_q    <= 4'd0;
      op_q      <= OP_ADD;
      result_q  <= 7'd0;
      score_q   <= 7'd0;
      guess_q   <= 4'd0;
      timer_q   <= 32'd0;
      correct_q <= 1'b0;
      cpulse_q  <= 1'b0;
      tpulse_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_q     <= bus.set_i;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      op_q      <= op_d;
      result_q  <= result_d;
      score_q   <= score_d;
      guess_q   <= guess_d;
      timer_q   <= timer_d;
      correct_q <= correct_d;
      cpulse_q  <= cpulse_d;
      tpulse_q  <= tpulse_d;
    end
  end

  assign bus.num1_o          = num1_q;
  assign bus.num2_o          = num2_q;
  assign bus.operator_o      = op_q;
  assign bus.result_o        = result_q;
  assign bus.score_o         = score_q;
  assign bus.round_active_o  = (state_q != ST_IDLE);
  assign bus.correct_pulse_o = cpulse_q;
  assign bus.timeout_pulse_o = tpulse_q;
  assign bus.motor_en_o      = (state_q == ST_SHOW) && correct_q;
  assign bus.state_dbg_o     = state_q;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Randomized round-by-round bench for quiz_round_controller against an arithmetic
// model of the quiz rules and a cycle-indexed view of the round timeline.
module tb_quiz_round_controller;

  localparam int unsigned TMO   = 20;
  localparam int unsigned SHOWC = 5;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          MAXS  = 99;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int exp_score = 0;
  logic [15:0] ref_lfsr;

  quiz_round_if bus();

  quiz_round_controller #(
    .ANSWER_TIMEOUT(TMO), .SHOW_CYCLES(SHOWC), .LFSR_SEED(SEED), .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Random source the round draws from: one Galois step (taps 0xB400) per clock.
  always @(posedge clk or negedge reset) begin
    if (!reset) ref_lfsr <= SEED;
    else        ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic int ref_apply(input int a, input int b, input int op);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      default: return (b == 0) ? -1 : a / b;
    endcase
  endfunction

  // mode 0: matching guess, 1: guess_in as given, 2: no answer, 3: wrong one-hot
  task automatic run_round(input int mode, input logic [3:0] guess_in, input int stale, input bit poke_set);
    int a, b, n1, n2, op, res, k;
    logic [15:0] snap;
    logic [3:0] drv;
    bit exp_ok;
    if (stale > 0) bus.switch_i = 4'b0001;
    bus.set_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.state_dbg_o !== 3'd1 || bus.round_active_o !== 1'b1) begin
      miscompares++;
      $display("FAIL gen_entry: state=%0d active=%0b, required state=1 active=1", bus.state_dbg_o, bus.round_active_o);
    end
    snap = ref_lfsr;
    a = int'(snap[3:0]); if (a >= 10) a -= 10;
    b = int'(snap[7:4]); if (b >= 10) b -= 10;
    n1 = (a > b) ? a : b;
    n2 = (a > b) ? b : a;
    op = int'(snap[9:8]);
    if (op == 3 && n2 == 0) op = 0;
    @(negedge clk);
    bus.set_i = 1'b0;
    vectors++;
    if (bus.state_dbg_o !== 3'd2 || bus.num1_o !== 4'(n1) || bus.num2_o !== 4'(n2) || bus.operator_o !== 2'(op)) begin
      miscompares++;
      $display("FAIL operands: state=%0d num1=%0d num2=%0d op=%0d, required state=2 num1=%0d num2=%0d op=%0d",
               bus.state_dbg_o, bus.num1_o, bus.num2_o, bus.operator_o, n1, n2, op);
    end
    res = ref_apply(n1, n2, op);
    @(negedge clk);
    vectors++;
    if (bus.state_dbg_o !== 3'd3 || bus.result_o !== 7'(res) || n1 < n2 || (op == 3 && n2 == 0)) begin
      miscompares++;
      $display("FAIL result: state=%0d result=%0d, required state=3 result=%0d", bus.state_dbg_o, bus.result_o, res);
    end
    for (int i = 0; i < stale; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.state_dbg_o !== 3'd3) begin
        miscompares++;
        $display("FAIL stale_hold: state=%0d, required 3", bus.state_dbg_o);
      end
    end
    bus.switch_i = 4'd0;
    @(negedge clk);
    vectors++;
    if (bus.state_dbg_o !== 3'd4) begin
      miscompares++;
      $display("FAIL wait_entry: state=%0d, required 4", bus.state_dbg_o);
    end
    exp_ok = 1'b0;
    if (mode == 2) begin
      for (int n = stale + 2; n <= int'(TMO); n++) begin
        if (poke_set) bus.set_i = n[0];
        @(negedge clk);
        vectors++;
        if (n < int'(TMO)) begin
          if (bus.state_dbg_o !== 3'd4 || bus.timeout_pulse_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: idx=%0d state=%0d tpulse=%0b, required state=4 tpulse=0", n, bus.state_dbg_o, bus.timeout_pulse_o);
          end
        end else if (bus.state_dbg_o !== 3'd6 || bus.timeout_pulse_o !== 1'b1 ||
                     bus.score_o !== 7'(exp_score) || bus.correct_pulse_o !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout: state=%0d tpulse=%0b score=%0d, required state=6 tpulse=1 score=%0d",
                   bus.state_dbg_o, bus.timeout_pulse_o, bus.score_o, exp_score);
        end
      end
      bus.set_i = 1'b0;
    end else begin
      drv = guess_in;
      if (mode == 0 || mode == 3) begin
        for (k = 0; k < 4; k++)
          if ((ref_apply(n1, n2, k) == res) == (mode == 0)) break;
        drv = 4'(1 << k);
      end
      if ($countones(drv) == 1) begin
        for (k = 0; k < 4; k++) if (drv[k]) break;
        exp_ok = (ref_apply(n1, n2, k) == res);
      end
      bus.switch_i = drv;
      @(negedge clk);
      bus.switch_i = 4'd0;
      vectors++;
      if (bus.state_dbg_o !== 3'd5) begin
        miscompares++;
        $display("FAIL judge_entry: state=%0d, required 5", bus.state_dbg_o);
      end
      if (exp_ok && exp_score < MAXS) exp_score++;
      @(negedge clk);
      vectors++;
      if (bus.state_dbg_o !== 3'd6 || bus.correct_pulse_o !== exp_ok || bus.score_o !== 7'(exp_score) || bus.timeout_pulse_o !== 1'b0) begin
        miscompares++;
        $display("FAIL judge: guess=%b state=%0d cpulse=%0b score=%0d, required state=6 cpulse=%0b score=%0d",
                 drv, bus.state_dbg_o, bus.correct_pulse_o, bus.score_o, exp_ok, exp_score);
      end
    end
    for (int i = 0; i < int'(SHOWC); i++) begin
      vectors++;
      if (bus.state_dbg_o !== 3'd6 || bus.motor_en_o !== exp_ok ||
          (i > 0 && (bus.correct_pulse_o !== 1'b0 || bus.timeout_pulse_o !== 1'b0))) begin
        miscompares++;
        $display("FAIL show: idx=%0d state=%0d motor=%0b cp=%0b tp=%0b, required state=6 motor=%0b",
                 i, bus.state_dbg_o, bus.motor_en_o, bus.correct_pulse_o, bus.timeout_pulse_o, exp_ok);
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.state_dbg_o !== 3'd0 || bus.motor_en_o !== 1'b0 || bus.round_active_o !== 1'b0 || bus.result_o !== 7'(res)) begin
      miscompares++;
      $display("FAIL idle_return: state=%0d motor=%0b active=%0b result=%0d, required state=0 motor=0 active=0 result=%0d",
               bus.state_dbg_o, bus.motor_en_o, bus.round_active_o, bus.result_o, res);
    end
  endtask

  task automatic test_reset();
    bus.set_i = 1'b0;
    bus.switch_i = 4'd0;
    reset = 1'b0;
    exp_score = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.state_dbg_o !== 3'd0 || bus.num1_o !== 4'd0 || bus.num2_o !== 4'd0 || bus.operator_o !== 2'd0 ||
          bus.result_o !== 7'd0 || bus.score_o !== 7'd0 || bus.round_active_o !== 1'b0 ||
          bus.correct_pulse_o !== 1'b0 || bus.timeout_pulse_o !== 1'b0 || bus.motor_en_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle: cyc=%0d state=%0d n1=%0d n2=%0d op=%0d res=%0d score=%0d, required all 0",
                 i, bus.state_dbg_o, bus.num1_o, bus.num2_o, bus.operator_o, bus.result_o, bus.score_o);
      end
    end
  endtask

  task automatic test_set_hold();
    int gens = 0;
    bus.set_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.state_dbg_o === 3'd1) gens++;
    end
    bus.set_i = 1'b0;
    vectors++;
    if (gens != 1 || bus.state_dbg_o !== 3'd0 || bus.score_o !== 7'(exp_score)) begin
      miscompares++;
      $display("FAIL set_hold: rounds=%0d state=%0d, required rounds=1 state=0", gens, bus.state_dbg_o);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();      run_round(2, 4'd0, 0, 1'b1); endtask
  task automatic test_correct();      run_round(0, 4'd0, 0, 1'b0); endtask
  task automatic test_wrong();
    run_round(1, 4'b0011, 0, 1'b0);
    run_round(3, 4'd0, 0, 1'b0);
  endtask
  task automatic test_stale();        run_round(0, 4'd0, 4, 1'b0); endtask
  task automatic test_saturation();
    repeat (120) run_round(0, 4'd0, 0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    bus.set_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.set_i = 1'b0;
    vectors++;
    if (bus.state_dbg_o !== 3'd4) begin
      miscompares++;
      $display("FAIL pre_reset_wait: state=%0d, required 4", bus.state_dbg_o);
    end
    #2 reset = 1'b0;
    exp_score = 0;
    #1;
    vectors++;
    if (bus.state_dbg_o !== 3'd0 || bus.score_o !== 7'd0 || bus.num1_o !== 4'd0 || bus.result_o !== 7'd0 ||
        bus.correct_pulse_o !== 1'b0 || bus.timeout_pulse_o !== 1'b0 || bus.round_active_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: state=%0d score=%0d cp=%0b tp=%0b, required state=0 score=0 cp=0 tp=0",
               bus.state_dbg_o, bus.score_o, bus.correct_pulse_o, bus.timeout_pulse_o);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.state_dbg_o !== 3'd0 || bus.timeout_pulse_o !== 1'b0 || bus.score_o !== 7'd0) begin
      miscompares++;
      $display("FAIL post_reset: state=%0d tp=%0b score=%0d, required 0 0 0", bus.state_dbg_o, bus.timeout_pulse_o, bus.score_o);
    end
  endtask

  task automatic test_random();
    int r, stale;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      stale = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (r == 0)      run_round(2, 4'd0, stale, 1'b0);
      else if (r <= 3) run_round(1, 4'($urandom_range(1, 15)), stale, 1'b0);
      else if (r == 4) run_round(3, 4'd0, stale, 1'b0);
      else             run_round(0, 4'd0, stale, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_set_hold();
    test_timeout();
    test_correct();
    test_wrong();
    test_stale();
    test_saturation();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
